// File: rtl/vga_sync_if.sv
// vga_sync_if: raster counters, decodes and strobes produced by the VGA timing generator
interface vga_sync_if;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    logic       update_window;
    logic [7:0] frame_count;
    modport master (
        output h_cnt, v_cnt, video_on, hsync, vsync,
        output line_start, frame_start, vblank_start, update_window, frame_count
    );
    modport slave (
        input h_cnt, v_cnt, video_on, hsync, vsync,
        input line_start, frame_start, vblank_start, update_window, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with decodes registered against next counter state
module vga_sync_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    vga_sync_if.master bus
);
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       r_run;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_video_on;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_vblank_start;
    logic       r_update_window;
    logic [7:0] r_frame_count;
    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_frame_wrap;

    // Next raster position; the first edge after reset presents (0,0) with live decodes
    always_comb begin
        w_h_wrap     = r_h_cnt == H_LAST;
        w_v_wrap     = r_v_cnt == V_LAST;
        w_frame_wrap = r_run && w_h_wrap && w_v_wrap;
        w_h_nxt      = (!r_run || w_h_wrap) ? '0 : r_h_cnt + 10'd1;
        w_v_nxt      = (!r_run || (w_h_wrap && w_v_wrap)) ? '0 : (w_h_wrap ? r_v_cnt + 10'd1 : r_v_cnt);
    end

    // Counters and decodes update together so outputs never skew against h_cnt/v_cnt
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_run           <= 1'b0;
            r_h_cnt         <= '0;
            r_v_cnt         <= '0;
            r_video_on      <= 1'b0;
            r_hsync         <= ~SYNC_ACTIVE;
            r_vsync         <= ~SYNC_ACTIVE;
            r_line_start    <= 1'b0;
            r_frame_start   <= 1'b0;
            r_vblank_start  <= 1'b0;
            r_update_window <= 1'b0;
            r_frame_count   <= '0;
        end else begin
            r_run           <= 1'b1;
            r_h_cnt         <= w_h_nxt;
            r_v_cnt         <= w_v_nxt;
            r_video_on      <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
            r_hsync         <= (w_h_nxt >= H_SYNC_BEG && w_h_nxt < H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync         <= (w_v_nxt >= V_SYNC_BEG && w_v_nxt < V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_line_start    <= w_h_nxt == '0;
            r_frame_start   <= (w_h_nxt == '0) && (w_v_nxt == '0);
            r_vblank_start  <= (w_h_nxt == '0) && (w_v_nxt == V_VIS);
            r_update_window <= w_v_nxt >= V_VIS;
            r_frame_count   <= w_frame_wrap ? r_frame_count + 8'd1 : r_frame_count;
        end
    end

    assign bus.h_cnt         = r_h_cnt;
    assign bus.v_cnt         = r_v_cnt;
    assign bus.video_on      = r_video_on;
    assign bus.hsync         = r_hsync;
    assign bus.vsync         = r_vsync;
    assign bus.line_start    = r_line_start;
    assign bus.frame_start   = r_frame_start;
    assign bus.vblank_start  = r_vblank_start;
    assign bus.update_window = r_update_window;
    assign bus.frame_count   = r_frame_count;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for a full-size raster and a shrunken 15x11 raster
module tb_vga_sync_gen;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       vb;
        logic       uw;
        logic [7:0] fc;
    } obs_t;

    typedef struct packed {
        int   t;
        obs_t o;
    } ent_t;

    typedef struct {
        int t;
        int h;
        int v;
        bit vo;
        bit hs;
    } dir_t;

    localparam obs_t RST_OBS = '{h: 10'd0, v: 10'd0, vo: 1'b0, hs: 1'b1, vs: 1'b1,
                                 ls: 1'b0, fs: 1'b0, vb: 1'b0, uw: 1'b0, fc: 8'd0};

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_a = 0;
    int   t_b = 0;
    int   last_ls_a = -1;
    int   last_fs_b = -1;
    ent_t q_a[$];
    ent_t q_b[$];
    dir_t dirs[10];
    obs_t obs_a;
    obs_t obs_b;

    vga_sync_if bus_a();
    vga_sync_if bus_b();

    vga_sync_gen u_full (
        .clk_25mhz (clk),
        .rst       (rst_a),
        .bus       (bus_a)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2)
    ) u_small (
        .clk_25mhz (clk),
        .rst       (rst_b),
        .bus       (bus_b)
    );

    assign obs_a = {bus_a.h_cnt, bus_a.v_cnt, bus_a.video_on, bus_a.hsync, bus_a.vsync, bus_a.line_start,
                    bus_a.frame_start, bus_a.vblank_start, bus_a.update_window, bus_a.frame_count};
    assign obs_b = {bus_b.h_cnt, bus_b.v_cnt, bus_b.video_on, bus_b.hsync, bus_b.vsync, bus_b.line_start,
                    bus_b.frame_start, bus_b.vblank_start, bus_b.update_window, bus_b.frame_count};

    always #5 clk = ~clk;

    function automatic obs_t model(input int t, input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vbk);
        int   ht = hv + hf + hsw + hb;
        int   vt = vv + vf + vsw + vbk;
        int   h = t % ht;
        int   v = (t / ht) % vt;
        obs_t o;
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.vo = h < hv && v < vv;
        o.hs = !(h >= hv + hf && h < hv + hf + hsw);
        o.vs = !(v >= vv + vf && v < vv + vf + vsw);
        o.ls = h == 0;
        o.fs = h == 0 && v == 0;
        o.vb = h == 0 && v == vv;
        o.uw = v >= vv;
        o.fc = 8'((t / (ht * vt)) % 256);
        return o;
    endfunction

    task automatic check(input string nm, input int t, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got h=%0d v=%0d flags=%b fc=%0d expected h=%0d v=%0d flags=%b fc=%0d",
                     nm, t, got.h, got.v, got[15:8], got.fc, exp.h, exp.v, exp[15:8], exp.fc);
        end
    endtask

    task automatic step(input bit ra, input bit rb);
        rst_a = ra;
        rst_b = rb;
        @(posedge clk);
        #1;
        if (ra) begin
            q_a.push_back('{t: -1, o: RST_OBS});
            t_a = 0;
        end else begin
            q_a.push_back('{t: t_a, o: model(t_a, 640, 16, 96, 48, 480, 10, 2, 33)});
            t_a++;
        end
        if (rb) begin
            q_b.push_back('{t: -1, o: RST_OBS});
            t_b = 0;
        end else begin
            q_b.push_back('{t: t_b, o: model(t_b, 8, 2, 3, 2, 6, 1, 2, 2)});
            t_b++;
        end
    endtask

    // Monitor: pop the expected response for each DUT and compare against what it presents
    always @(negedge clk) begin
        ent_t e;
        cyc++;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("full_raster", e.t, obs_a, e.o);
            for (int k = 0; k < 10; k++) begin
                if (e.t == dirs[k].t) begin
                    checks++;
                    if (bus_a.h_cnt !== 10'(dirs[k].h) || bus_a.v_cnt !== 10'(dirs[k].v) ||
                        bus_a.video_on !== dirs[k].vo || bus_a.hsync !== dirs[k].hs) begin
                        errors++;
                        $display("FAIL directed_point t=%0d got h=%0d v=%0d vo=%b hs=%b expected h=%0d v=%0d vo=%b hs=%b",
                                 e.t, bus_a.h_cnt, bus_a.v_cnt, bus_a.video_on, bus_a.hsync,
                                 dirs[k].h, dirs[k].v, dirs[k].vo, dirs[k].hs);
                    end
                end
            end
            if (e.t < 0) last_ls_a = -1;
            else if (bus_a.line_start === 1'b1) begin
                if (last_ls_a >= 0) begin
                    checks++;
                    if (cyc - last_ls_a != 800) begin
                        errors++;
                        $display("FAIL line_period got=%0d expected=800", cyc - last_ls_a);
                    end
                end
                last_ls_a = cyc;
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("small_raster", e.t, obs_b, e.o);
            if (e.t < 0) last_fs_b = -1;
            else if (bus_b.frame_start === 1'b1) begin
                if (last_fs_b >= 0) begin
                    checks++;
                    if (cyc - last_fs_b != 165) begin
                        errors++;
                        $display("FAIL frame_period got=%0d expected=165", cyc - last_fs_b);
                    end
                end
                last_fs_b = cyc;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        dirs[0] = '{t: 0,    h: 0,   v: 0, vo: 1'b1, hs: 1'b1};
        dirs[1] = '{t: 639,  h: 639, v: 0, vo: 1'b1, hs: 1'b1};
        dirs[2] = '{t: 640,  h: 640, v: 0, vo: 1'b0, hs: 1'b1};
        dirs[3] = '{t: 655,  h: 655, v: 0, vo: 1'b0, hs: 1'b1};
        dirs[4] = '{t: 656,  h: 656, v: 0, vo: 1'b0, hs: 1'b0};
        dirs[5] = '{t: 751,  h: 751, v: 0, vo: 1'b0, hs: 1'b0};
        dirs[6] = '{t: 752,  h: 752, v: 0, vo: 1'b0, hs: 1'b1};
        dirs[7] = '{t: 799,  h: 799, v: 0, vo: 1'b0, hs: 1'b1};
        dirs[8] = '{t: 800,  h: 0,   v: 1, vo: 1'b1, hs: 1'b1};
        dirs[9] = '{t: 2300, h: 700, v: 2, vo: 1'b0, hs: 1'b0};
        repeat (5) step(1'b1, 1'b1);
        repeat (2301) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        repeat (45000) step(1'b0, 1'b0);
        guard = 0;
        while ((t_b % 165) != 117 && guard < 200) begin
            step(1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL small_reset_align got guard=%0d expected below 200", guard);
        end
        step(1'b0, 1'b1);
        repeat (400) step(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d/%0d expected=0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator that drives the VGA pixel path: produces `h_cnt`, `v_cnt`, `video_on`, `hsync`, `vsync` for the 640x480@60 Hz raster, plus frame and line strobes. Its counter outputs feed the display renderer directly. Its frame strobes give the trading core a tear-free window to update the price, spread and trade-count values the renderer draws.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, sync pulse level (0 = active-low)

Ports:
- clk_25mhz  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- h_cnt  out  10  pixel column, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800)
- v_cnt  out  10  line, 0..V_TOTAL-1 (V_TOTAL = sum of V_* = 525)
- video_on  out  1  high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE
- hsync  out  1  SYNC_ACTIVE when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, else ~SYNC_ACTIVE
- vsync  out  1  SYNC_ACTIVE when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC, else ~SYNC_ACTIVE
- line_start  out  1  one-cycle pulse when h_cnt == 0
- frame_start  out  1  one-cycle pulse when h_cnt == 0 and v_cnt == 0
- vblank_start  out  1  one-cycle pulse when h_cnt == 0 and v_cnt == V_VISIBLE
- update_window  out  1  level, high when v_cnt >= V_VISIBLE (vertical blanking)
- frame_count  out  8  frames completed since reset, wraps 255 -> 0

## Operation
- The horizontal counter increments every clock. At H_TOTAL-1 it wraps to 0, and the vertical counter advances on that same edge.
- The vertical counter wraps V_TOTAL-1 -> 0 on the edge where h_cnt wraps from H_TOTAL-1.
- Both counters are registers. They never take a value outside their range, including after reset.
- All decoded outputs are registered. They are computed from the next counter values, so every output is coherent with the `h_cnt`/`v_cnt` shown in the same cycle. Zero skew between counters and decodes.
- `frame_count` increments on the edge that takes (h,v) from (H_TOTAL-1, V_TOTAL-1) to (0,0). It therefore shows its new value in the same cycle `frame_start` is high.
- `update_window` is high for lines V_VISIBLE..V_TOTAL-1, which is 45 lines or 36000 cycles. Consumers change renderer inputs only while this is high.
- Effective phases, horizontal: VISIBLE 0-639, FRONT 640-655, SYNC 656-751, BACK 752-799.
- Effective phases, vertical: VISIBLE 0-479, FRONT 480-489, SYNC 490-491, BACK 492-524.

## Timing
Reset (`rst` high on a clock edge) loads:
- h_cnt = 0, v_cnt = 0, frame_count = 0
- video_on = 0, line_start = 0, frame_start = 0, vblank_start = 0, update_window = 0
- hsync = vsync = ~SYNC_ACTIVE

While `rst` is held, outputs stay at these values.

First cycle after `rst` deasserts:
- h_cnt = 0, v_cnt = 0, video_on = 1, line_start = 1, frame_start = 1, frame_count = 0.
- This first frame_start is not counted as a completed frame.

Latency and cadence:
- Output latency from counter state is 0 cycles, because decodes are registered against next state.
- Line period is 800 cycles. Frame period is 420000 cycles.
- `line_start` asserts every 800 cycles. `frame_start` and `vblank_start` each assert once per 420000 cycles. `vblank_start` falls 384000 cycles after `frame_start`.

Boundary conditions:
- Reset mid-line or mid-frame restarts at (0,0) on the next edge, with no partial sync pulse carried over.
- At the frame wrap (799,524)->(0,0), both counters wrap on the same edge. `update_window` falls and `frame_start` rises in that same cycle.
- `frame_count` 255 -> 0 wrap occurs silently, with no flag.

## Test plan
- Reset release: hold rst 5 cycles, then drop it -> first cycle shows h=0, v=0, video_on=1, frame_start=1, hsync=vsync=1, frame_count=0.
- Horizontal decode: run 1 line -> video_on high exactly cycles 0-639. hsync low exactly for h=656..751 (96 cycles). h wraps 799->0 with v 0->1.
- Vertical decode: run 1 frame -> vsync low exactly for v=490..491 (1600 cycles). update_window high from v=480 to end of v=524. vblank_start pulses once at (0,480).
- Frame cadence: run 3 frames -> frame_start spacing is exactly 420000 cycles. frame_count reads 0,1,2 at successive frame_start pulses.
- Mid-frame reset: assert rst at (h=700, v=300), which is inside the hsync pulse -> next cycle hsync=1, h=0, v=0, frame_count=0. The following frame timing is identical to the power-on case.
- Wrap: force 256 frames (or preload via a shortened-parameter build with H_TOTAL=10, V_TOTAL=5) -> frame_count goes 255->0 on the frame_start edge. No glitch on other outputs.
